// File: rtl/lfsr32_pkg.sv
// Shared definitions for the 32-bit Galois LFSR event counter and its decoder.
package lfsr32_pkg;

  localparam int unsigned LFSR_W = 32;

  localparam logic [LFSR_W-1:0] SEED0 = 32'h0000_0001;
  localparam logic [LFSR_W-1:0] SEED1 = 32'hA300_0000;

  // Taps 32,30,26,25 (1-based) as feedback mask for the right-shifting Galois form
  localparam logic [LFSR_W-1:0] TAP_MASK = 32'hA300_0000;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ ({LFSR_W{s[0]}} & TAP_MASK);
  endfunction

endpackage

// File: rtl/lfsr32_decode.sv
// Decodes a final Galois LFSR state back into a binary event count by
// replaying the sequence from SEED0 until it matches or MAX_STEPS is hit.
module lfsr32_decode
  import lfsr32_pkg::*;
#(
  parameter logic [LFSR_W-1:0] MAX_STEPS = 32'd100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] lfsr_state,
  input  logic              lfsr_ready,
  output logic [LFSR_W-1:0] count,
  output logic              valid,
  output logic              overflow,
  output logic              busy,
  output logic              missed
);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LFSR_W-1:0] r_target;
  logic [LFSR_W-1:0] r_ref;
  logic [LFSR_W-1:0] r_k;
  logic [LFSR_W-1:0] r_count;
  logic              r_overflow;
  logic              r_valid;
  logic              r_missed;

  logic [LFSR_W-1:0] w_target;
  logic [LFSR_W-1:0] w_ref;
  logic [LFSR_W-1:0] w_k;
  logic [LFSR_W-1:0] w_count;
  logic              w_overflow;
  logic              w_valid;
  logic              w_missed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_ref      <= SEED0;
      r_k        <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target;
      r_ref      <= w_ref;
      r_k        <= w_k;
      r_count    <= w_count;
      r_overflow <= w_overflow;
      r_valid    <= w_valid;
      r_missed   <= w_missed;
    end
  end

  // Match is checked before the limit, so k stops at MAX_STEPS and never wraps
  always_comb begin
    w_state_nxt = r_state;
    w_target    = r_target;
    w_ref       = r_ref;
    w_k         = r_k;
    w_count     = r_count;
    w_overflow  = r_overflow;
    w_valid     = 1'b0;
    w_missed    = 1'b0;
    case (r_state)
      IDLE: begin
        if (lfsr_ready) begin
          w_target    = lfsr_state;
          w_ref       = SEED0;
          w_k         = '0;
          w_state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        w_missed = lfsr_ready;
        if (r_ref == r_target) begin
          w_count     = r_k;
          w_overflow  = 1'b0;
          w_valid     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_k == MAX_STEPS) begin
          w_count     = MAX_STEPS;
          w_overflow  = 1'b1;
          w_valid     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_ref = lfsr_step(r_ref);
          w_k   = r_k + LFSR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign count    = r_count;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign busy     = (r_state == SEARCH);
  assign missed   = r_missed;

endmodule

// File: tb/tb_lfsr32_decode.sv
// Self-checking bench for lfsr32_decode: vector table, randomized captures
// against a sequence-replay model, and hand-written multi-cycle corner cases.
module tb_lfsr32_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_state, b_state;
  logic        a_ready, b_ready;
  logic [31:0] a_count, b_count;
  logic        a_valid, b_valid, a_ovf, b_ovf, a_busy, b_busy, a_missed, b_missed;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr32_decode u_dut (
    .clk(clk), .rst(rst), .lfsr_state(a_state), .lfsr_ready(a_ready),
    .count(a_count), .valid(a_valid), .overflow(a_ovf), .busy(a_busy), .missed(a_missed)
  );

  lfsr32_decode #(.MAX_STEPS(32'd16)) u_dut16 (
    .clk(clk), .rst(rst), .lfsr_state(b_state), .lfsr_ready(b_ready),
    .count(b_count), .valid(b_valid), .overflow(b_ovf), .busy(b_busy), .missed(b_missed)
  );

  function automatic logic [31:0] mstep(input logic [31:0] s);
    return {s[0], s[31], s[30] ^ s[0], s[29:27], s[26] ^ s[0], s[25] ^ s[0], s[24:1]};
  endfunction

  function automatic logic [31:0] mstate(input int unsigned n);
    logic [31:0] s = 32'h0000_0001;
    for (int unsigned i = 0; i < n; i++) s = mstep(s);
    return s;
  endfunction

  // Reference decode for the MAX_STEPS=16 instance: first index that matches, else overflow
  task automatic decode16(input logic [31:0] t, output logic [31:0] c, output logic o);
    logic [31:0] s = 32'h0000_0001;
    c = 32'd16;
    o = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (s == t) begin
        c = 32'(i);
        o = 1'b0;
        break;
      end
      s = mstep(s);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic run_one(input bit b16, input logic [31:0] st, input logic [31:0] ec,
                         input logic eo, input string nm);
    int lat = 0, busy_n = 0, miss_n = 0, budget;
    bit seen = 1'b0;
    budget = int'(ec) + 20;
    if (b16) begin b_state = st; b_ready = 1'b1; end
    else     begin a_state = st; a_ready = 1'b1; end
    @(negedge clk);
    a_ready = 1'b0;
    b_ready = 1'b0;
    for (int j = 0; j < budget; j++) begin
      if (b16 ? b_busy : a_busy) busy_n++;
      if (b16 ? b_missed : a_missed) miss_n++;
      if (b16 ? b_valid : a_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk({nm, ".valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, ".latency"}, 32'(lat), ec + 32'd1);
      chk({nm, ".count"}, b16 ? b_count : a_count, ec);
      chk({nm, ".overflow"}, 32'(b16 ? b_ovf : a_ovf), 32'(eo));
      chk({nm, ".busy_cycles"}, 32'(busy_n), ec + 32'd1);
      chk({nm, ".no_missed"}, 32'(miss_n), 32'd0);
      @(negedge clk);
      chk({nm, ".valid_single"}, 32'(b16 ? b_valid : a_valid), 32'd0);
      chk({nm, ".count_hold"}, b16 ? b_count : a_count, ec);
    end
  endtask

  typedef struct {
    bit          b16;
    logic [31:0] st;
    logic [31:0] ec;
    logic        eo;
    string       nm;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] t, c;
    logic        o;
    int          k, n_valid, n_miss, valid_j;
    logic [31:0] vcount;

    rst = 1'b1;
    a_state = '0; b_state = '0; a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.count", a_count, 32'd0);
    chk("reset.flags", {28'd0, a_valid, a_ovf, a_busy, a_missed}, 32'd0);
    chk("reset.flags16", {28'd0, b_valid, b_ovf, b_busy, b_missed}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = '{1'b0, 32'h0000_0001, 32'd0,    1'b0, "seed0"};
    tbl[1] = '{1'b0, 32'hA300_0000, 32'd1,    1'b0, "seed1"};
    tbl[2] = '{1'b0, mstate(1000),  32'd1000, 1'b0, "k1000"};
    tbl[3] = '{1'b1, 32'h0000_0000, 32'd16,   1'b1, "zero_ovf16"};
    tbl[4] = '{1'b1, mstate(16),    32'd16,   1'b0, "k16_at_max"};
    tbl[5] = '{1'b1, mstate(17),    32'd16,   1'b1, "k17_ovf16"};
    tbl[6] = '{1'b1, 32'h0000_0001, 32'd0,    1'b0, "seed0_16"};
    for (int i = 0; i < 7; i++) run_one(tbl[i].b16, tbl[i].st, tbl[i].ec, tbl[i].eo, tbl[i].nm);

    repeat (12) begin
      k = int'($urandom_range(0, 300));
      run_one(1'b0, mstate(k), 32'(k), 1'b0, "rand");
    end
    repeat (8) begin
      t = ($urandom_range(0, 1) == 0) ? mstate($urandom_range(0, 24)) : $urandom;
      decode16(t, c, o);
      run_one(1'b1, t, c, o, "rand16");
    end

    // Second ready 10 cycles into a count-50 search is dropped
    a_state = mstate(50); a_ready = 1'b1;
    n_valid = 0; n_miss = 0; valid_j = -1; vcount = '0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      a_ready = (j == 10);
      if (j == 10) a_state = mstate(7);
      if (a_missed) n_miss++;
      if (a_valid) begin n_valid++; valid_j = j; vcount = a_count; end
    end
    chk("drop.missed_pulses", 32'(n_miss), 32'd1);
    chk("drop.valid_pulses", 32'(n_valid), 32'd1);
    chk("drop.valid_cycle", 32'(valid_j), 32'd52);
    chk("drop.count", vcount, 32'd50);

    // Ready on the completion edge is also dropped and starts nothing
    a_state = mstate(5); a_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      a_ready = (j == 6);
      if (j == 7) begin
        chk("edge.valid", 32'(a_valid), 32'd1);
        chk("edge.missed", 32'(a_missed), 32'd1);
        chk("edge.count", a_count, 32'd5);
      end
      if (j == 8) chk("edge.no_restart", {30'd0, a_busy, a_missed}, 32'd0);
    end

    // Reset mid-search aborts without a valid pulse
    a_state = mstate(100); a_ready = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      a_ready = 1'b0;
    end
    chk("abort.busy_before", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort.count", a_count, 32'd0);
    chk("abort.flags", {28'd0, a_valid, a_ovf, a_busy, a_missed}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    for (int j = 0; j < 110; j++) begin
      @(negedge clk);
      if (a_valid || a_busy) n_valid++;
    end
    chk("abort.no_activity", 32'(n_valid), 32'd0);
    run_one(1'b0, mstate(3), 32'd3, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr32_decode.md
LFSR32_DECODE -- requirements
Module: lfsr32_decode

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 32'd100_000_000: search limit, i.e. the largest decodable event count.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port lfsr_state, input, 32 bits: final state of the upstream 32-bit Galois LFSR event counter.
REQ-005 SHALL have port lfsr_ready, input, 1 bit: single-cycle strobe; lfsr_state is valid when it is high.
REQ-006 SHALL have port count, output, 32 bits: decoded binary event count.
REQ-007 SHALL have port valid, output, 1 bit: single-cycle strobe; count and overflow are valid when it is high.
REQ-008 SHALL have port overflow, output, 1 bit: the last result hit MAX_STEPS without a match.
REQ-009 SHALL have port busy, output, 1 bit: high while a search is in progress.
REQ-010 SHALL have port missed, output, 1 bit: single-cycle pulse when an lfsr_ready is dropped.

Function
REQ-011 SHALL implement the same LFSR as upstream: taps 32,30,26,25 (1-based), Galois right-shift form.
- Step function: next = {s[0], s[31], s[30]^s[0], s[29:27], s[26]^s[0], s[25]^s[0], s[24:1]}.
REQ-012 SHALL treat SEED0 = 32'h0000_0001 as count 0; step(SEED0) = 32'hA300_0000 is count 1.
REQ-013 SHALL implement states IDLE and SEARCH.
REQ-014 IDLE with lfsr_ready=1 SHALL perform all of the following at that edge:
- target <= lfsr_state
- ref <= SEED0
- k <= 0
- go to SEARCH
REQ-015 In SEARCH, each edge SHALL take the first matching action, in priority order:
- ref==target: count <= k, overflow <= 0, valid pulse, go to IDLE.
- else k==MAX_STEPS: count <= MAX_STEPS, overflow <= 1, valid pulse, go to IDLE.
- else: ref <= step(ref), k <= k+1.
REQ-016 Latency SHALL be exactly k+1 cycles from the lfsr_ready sample edge to the valid high cycle, for decoded count k.
REQ-017 busy SHALL equal (state==SEARCH).
REQ-018 lfsr_ready high while in SEARCH SHALL be ignored and SHALL assert missed for one cycle.
- This includes the edge on which the search completes.
- A new capture is accepted only from IDLE, at the earliest on the cycle after the valid pulse.
REQ-019 count and overflow SHALL hold their last result until the next valid pulse.
REQ-020 target == 0 (the LFSR lock-up state, never reached) SHALL terminate via the overflow path.
REQ-021 k SHALL be a 32-bit unsigned counter and SHALL never wrap, because the MAX_STEPS limit is checked first.

Reset
REQ-022 On rst, the block SHALL asynchronously reset to:
- state = IDLE
- count = 0, valid = 0, overflow = 0, busy = 0, missed = 0
- target = 0, ref = SEED0, k = 0
REQ-023 rst asserted mid-search SHALL abort the search with no valid pulse; the first lfsr_ready after deassertion starts a fresh search.

Structure
REQ-024 Package lfsr32_pkg SHALL hold the following, shared with the upstream counter:
- SEED0 and SEED1 constants
- the tap list
- the step function
REQ-025 The state encoding SHALL be local to the module.
REQ-026 There SHALL be no sub-module; the step function from lfsr32_pkg replaces one.

Verification
REQ-027 Capture lfsr_state=32'h0000_0001 -> valid 1 cycle later, count=0, overflow=0.
REQ-028 Capture 32'hA300_0000 -> valid 2 cycles later, count=1.
REQ-029 Capture the state reached after 1000 model steps from SEED0 -> valid 1001 cycles later, count=1000; busy high for exactly 1001 cycles.
REQ-030 MAX_STEPS=16, capture 32'h0000_0000 -> valid 17 cycles later, count=16, overflow=1.
REQ-031 Capture state of count 50, pulse lfsr_ready again 10 cycles later -> missed pulses once, single valid with count=50.
REQ-032 Assert rst 20 cycles into a count-100 search -> all outputs 0 immediately, no valid pulse; the next capture of count 3 gives count=3.
